// File: rtl/bru_pkg.sv
// Shared types and constants for branch resolution.
package bru_pkg;
    `include "defines.svh"

    localparam int unsigned INST_AW = `INST_ADDR_WIDTH;
    localparam int unsigned REG_DW  = `REG_DATA_WIDTH;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } bru_state_e;
endpackage

// File: rtl/bru_cond.sv
// Conditional-branch comparator: evaluates funct3 against the two operands.
module bru_cond
    import bru_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [REG_DW-1:0] rs1_i,
    input  logic [REG_DW-1:0] rs2_i,
    output logic              taken_o
);
    logic eq_c;
    logic lt_s_c;
    logic lt_u_c;

    assign eq_c   = (rs1_i == rs2_i);
    assign lt_s_c = ($signed(rs1_i) < $signed(rs2_i));
    assign lt_u_c = (rs1_i < rs2_i);

    // Reserved encodings (010, 011) resolve as not taken.
    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            BEQ:     taken_o = eq_c;
            BNE:     taken_o = ~eq_c;
            BLT:     taken_o = lt_s_c;
            BGE:     taken_o = ~lt_s_c;
            BLTU:    taken_o = lt_u_c;
            BGEU:    taken_o = ~lt_u_c;
            default: taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/defines.svh
// Global datapath widths shared by the EXU blocks.
`ifndef BRU_DEFINES_SVH
`define BRU_DEFINES_SVH
`define INST_ADDR_WIDTH 32
`define REG_DATA_WIDTH 32
`endif

// File: rtl/bru_resolve.sv
// Branch resolution: compares real outcome with the fetch prediction and
// holds a redirect toward IFU until accepted, with resolve/mispredict counters.
module bru_resolve
    import bru_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    input  logic [INST_AW-1:0]   pc_i,
    input  logic                 is_branch_i,
    input  logic                 is_jal_i,
    input  logic                 is_jalr_i,
    input  logic [2:0]           funct3_i,
    input  logic [31:0]          imm_i,
    input  logic [REG_DW-1:0]    rs1_data_i,
    input  logic [REG_DW-1:0]    rs2_data_i,
    input  logic                 pred_taken_i,
    input  logic [INST_AW-1:0]   pred_addr_i,
    output logic                 redirect_valid_o,
    output logic [INST_AW-1:0]   redirect_addr_o,
    input  logic                 redirect_ready_i,
    output logic                 flush_o,
    output logic                 stall_o,
    output logic [CNT_WIDTH-1:0] br_cnt_o,
    output logic [CNT_WIDTH-1:0] mis_cnt_o
);
    bru_state_e           state_q, state_d;
    logic [INST_AW-1:0]   addr_q, addr_d;
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

    logic               cond_taken_c;
    logic               is_ctrl_c;
    logic               actual_taken_c;
    logic               mispredict_c;
    logic [INST_AW-1:0] pc_seq_c;
    logic [INST_AW-1:0] pc_rel_c;
    logic [INST_AW-1:0] jalr_sum_c;
    logic [INST_AW-1:0] target_c;
    logic [INST_AW-1:0] redir_addr_c;

    bru_cond u_cond (
        .funct3_i (funct3_i),
        .rs1_i    (rs1_data_i),
        .rs2_i    (rs2_data_i),
        .taken_o  (cond_taken_c)
    );

    assign pc_seq_c   = pc_i + INST_AW'(4);
    assign pc_rel_c   = pc_i + INST_AW'(imm_i);
    assign jalr_sum_c = INST_AW'(rs1_data_i) + INST_AW'(imm_i);
    assign is_ctrl_c  = is_branch_i | is_jal_i | is_jalr_i;

    // Actual outcome; overlapping type flags resolve JALR > JAL > branch.
    always_comb begin
        actual_taken_c = 1'b0;
        target_c       = pc_seq_c;
        if (is_jalr_i) begin
            actual_taken_c = 1'b1;
            target_c       = {jalr_sum_c[INST_AW-1:1], 1'b0};
        end else if (is_jal_i) begin
            actual_taken_c = 1'b1;
            target_c       = pc_rel_c;
        end else if (is_branch_i) begin
            actual_taken_c = cond_taken_c;
            target_c       = cond_taken_c ? pc_rel_c : pc_seq_c;
        end
        mispredict_c = (pred_taken_i != actual_taken_c) ||
                       (actual_taken_c && (pred_addr_i != target_c));
        redir_addr_c = actual_taken_c ? target_c : pc_seq_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // Next state, counter update and the handshake flush pulse.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        flush_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (is_ctrl_c) br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
                    if (mispredict_c) begin
                        mis_cnt_d = mis_cnt_q + CNT_WIDTH'(1);
                        addr_d    = redir_addr_c;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (redirect_ready_i) begin
                    flush_o = ~rst;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign redirect_valid_o = (state_q == REQ);
    assign stall_o          = (state_q == REQ);
    assign redirect_addr_o  = addr_q;
    assign br_cnt_o         = br_cnt_q;
    assign mis_cnt_o        = mis_cnt_q;
endmodule

// File: tb/tb_bru_resolve.sv
// Directed bench for bru_resolve with a spec-level reference model.
module tb_bru_resolve;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [31:0]   pc;
    logic          is_br, is_jal, is_jalr;
    logic [2:0]    f3;
    logic [31:0]   imm, rs1, rs2;
    logic          pt;
    logic [31:0]   pa;
    logic          redirect_valid_o;
    logic [31:0]   redirect_addr_o;
    logic          ready;
    logic          flush_o, stall_o;
    logic [CW-1:0] br_cnt_o, mis_cnt_o;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model state
    bit          m_pend = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_br = 0, m_mis = 0;

    bru_resolve #(.CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid),
        .pc_i             (pc),
        .is_branch_i      (is_br),
        .is_jal_i         (is_jal),
        .is_jalr_i        (is_jalr),
        .funct3_i         (f3),
        .imm_i            (imm),
        .rs1_data_i       (rs1),
        .rs2_data_i       (rs2),
        .pred_taken_i     (pt),
        .pred_addr_i      (pa),
        .redirect_valid_o (redirect_valid_o),
        .redirect_addr_o  (redirect_addr_o),
        .redirect_ready_i (ready),
        .flush_o          (flush_o),
        .stall_o          (stall_o),
        .br_cnt_o         (br_cnt_o),
        .mis_cnt_o        (mis_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural resolution rules, computed directly from the ISA semantics.
    function automatic void resolve(output bit ctrl, output bit mp, output logic [31:0] nxt);
        bit          tk;
        logic [31:0] tgt;
        longint      sa, sb;
        longint      ua, ub;
        sa = longint'($signed(rs1));
        sb = longint'($signed(rs2));
        ua = longint'({32'b0, rs1});
        ub = longint'({32'b0, rs2});
        ctrl = is_br || is_jal || is_jalr;
        tk = 1'b0;
        tgt = pc + 32'd4;
        if (is_jalr) begin
            tk = 1'b1;
            tgt = rs1 + imm;
            tgt[0] = 1'b0;
        end else if (is_jal) begin
            tk = 1'b1;
            tgt = pc + imm;
        end else if (is_br) begin
            case (f3)
                3'd0: tk = (ua == ub);
                3'd1: tk = (ua != ub);
                3'd4: tk = (sa < sb);
                3'd5: tk = (sa >= sb);
                3'd6: tk = (ua < ub);
                3'd7: tk = (ua >= ub);
                default: tk = 1'b0;
            endcase
            if (tk) tgt = pc + imm;
        end
        mp  = (pt != tk) || (tk && (pa != tgt));
        nxt = tk ? tgt : pc + 32'd4;
    endfunction

    always @(posedge clk) begin
        bit c, m;
        logic [31:0] n;
        if (rst) begin
            m_pend = 1'b0; m_addr = '0; m_br = 0; m_mis = 0;
        end else if (m_pend) begin
            if (ready) m_pend = 1'b0;
        end else if (req_valid) begin
            resolve(c, m, n);
            if (c) m_br = (m_br + 1) % 16;
            if (m) begin
                m_mis = (m_mis + 1) % 16;
                m_pend = 1'b1;
                m_addr = n;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid",   64'(redirect_valid_o), 64'(m_pend));
            check("stall",   64'(stall_o), 64'(m_pend));
            check("addr",    64'(redirect_addr_o), 64'(m_addr));
            check("flush",   64'(flush_o), 64'(m_pend && ready && !rst));
            check("br_cnt",  64'(br_cnt_o), 64'(m_br));
            check("mis_cnt", 64'(mis_cnt_o), 64'(m_mis));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] ipc, input logic b, input logic j, input logic jr,
                         input logic [2:0] ff, input logic [31:0] iimm, input logic [31:0] a,
                         input logic [31:0] bb, input logic ipt, input logic [31:0] ipa);
        pc = ipc; is_br = b; is_jal = j; is_jalr = jr; f3 = ff; imm = iimm;
        rs1 = a; rs2 = bb; pt = ipt; pa = ipa; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ack(input int hold);
        int waited = 0;
        while (!redirect_valid_o && waited < 10) begin
            tick();
            waited++;
        end
        if (!redirect_valid_o) begin
            tests++; fails++;
            $display("FAIL ack_timeout: redirect_valid_o=0 expected 1");
        end
        repeat (hold) tick();
        ready = 1'b1;
        #1;
        check("flush_hs", 64'(flush_o), 64'd1);
        tick();
        ready = 1'b0;
        check("idle_after_hs", 64'(redirect_valid_o), 64'd0);
        check("flush_one_cycle", 64'(flush_o), 64'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; ready = 1'b0;
        pc = '0; is_br = 0; is_jal = 0; is_jalr = 0; f3 = '0; imm = '0;
        rs1 = '0; rs2 = '0; pt = 0; pa = '0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_valid", 64'(redirect_valid_o), 64'd0);
        check("rst_addr",  64'(redirect_addr_o), 64'd0);
        check("rst_br",    64'(br_cnt_o), 64'd0);
        rst = 1'b0;
        tick();

        // BEQ correctly predicted taken
        issue(32'h8000_0100, 1, 0, 0, 3'd0, 32'hFFFF_FFF0, 32'd5, 32'd5, 1, 32'h8000_00F0);
        check("beq_valid", 64'(redirect_valid_o), 64'd0);
        check("beq_stall", 64'(stall_o), 64'd0);
        check("beq_br",    64'(br_cnt_o), 64'd1);
        check("beq_mis",   64'(mis_cnt_o), 64'd0);

        // BNE predicted taken but not taken; ignored request while stalled
        issue(32'h8000_0200, 1, 0, 0, 3'd1, 32'h20, 32'd7, 32'd7, 1, 32'h8000_0220);
        check("bne_valid", 64'(redirect_valid_o), 64'd1);
        check("bne_addr",  64'(redirect_addr_o), 64'h8000_0204);
        check("bne_stall", 64'(stall_o), 64'd1);
        issue(32'h8000_0900, 0, 1, 0, 3'd0, 32'h100, 32'd0, 32'd0, 0, 32'h0);
        tick(); tick();
        check("bne_hold_addr", 64'(redirect_addr_o), 64'h8000_0204);
        check("bne_hold_br",   64'(br_cnt_o), 64'd2);
        ack(0);

        // BLT taken vs BLTU not taken on the same operands
        issue(32'h8000_0300, 1, 0, 0, 3'd4, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 32'h0);
        check("blt_addr", 64'(redirect_addr_o), 64'h8000_0340);
        ack(1);
        issue(32'h8000_0300, 1, 0, 0, 3'd6, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 32'h0);
        check("bltu_valid", 64'(redirect_valid_o), 64'd0);

        // JALR with low bit cleared
        issue(32'h8000_0400, 0, 0, 1, 3'd0, 32'd4, 32'h8000_0203, 32'd0, 1, 32'h8000_0200);
        check("jalr_addr", 64'(redirect_addr_o), 64'h8000_0206);
        ack(2);
        issue(32'h8000_0400, 0, 0, 1, 3'd0, 32'd4, 32'h8000_0203, 32'd0, 1, 32'h8000_0206);
        check("jalr_ok_valid", 64'(redirect_valid_o), 64'd0);

        // Non-control instruction predicted taken
        issue(32'h8000_0010, 0, 0, 0, 3'd0, 32'h0, 32'd0, 32'd0, 1, 32'h8000_0080);
        check("nc_addr", 64'(redirect_addr_o), 64'h8000_0014);
        check("nc_br",   64'(br_cnt_o), 64'd6);
        check("nc_mis",  64'(mis_cnt_o), 64'd4);
        ack(0);

        // Remaining conditions, ready in IDLE, reserved funct3, flag priority
        ready = 1'b1;
        issue(32'h8000_0500, 1, 0, 0, 3'd5, 32'h10, 32'd3, 32'd3, 1, 32'h8000_0510);
        issue(32'h8000_0600, 1, 0, 0, 3'd7, 32'h10, 32'd1, 32'd2, 0, 32'h0);
        ready = 1'b0;
        issue(32'h8000_0700, 1, 0, 0, 3'd2, 32'h10, 32'd0, 32'd0, 1, 32'h8000_0710);
        ack(0);
        issue(32'h8000_0800, 1, 1, 0, 3'd1, 32'h0000_1000, 32'd9, 32'd9, 1, 32'h8000_0804);
        check("prio_addr", 64'(redirect_addr_o), 64'h8000_1800);
        ack(0);

        // Reset while a redirect is pending
        issue(32'h8000_0A00, 0, 1, 0, 3'd0, 32'h20, 32'd0, 32'd0, 0, 32'h0);
        rst = 1'b1; ready = 1'b1;
        #1;
        check("rst_req_flush", 64'(flush_o), 64'd0);
        tick();
        rst = 1'b0; ready = 1'b0;
        check("rst_req_valid", 64'(redirect_valid_o), 64'd0);
        check("rst_req_br",    64'(br_cnt_o), 64'd0);
        check("rst_req_mis",   64'(mis_cnt_o), 64'd0);

        // Counter wrap at 16 correctly predicted branches
        for (int i = 0; i < 16; i++) begin
            issue(32'h8000_0000 + 32'(i * 4), 1, 0, 0, 3'd0, 32'h40, 32'd1, 32'd2, 0, 32'h0);
            if (i == 14) check("wrap_15", 64'(br_cnt_o), 64'd15);
        end
        check("wrap_0", 64'(br_cnt_o), 64'd0);
        tick(); tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
